// File: rtl/fir_mac_sequencer.sv
// Sequencer for one FIR multiply-accumulate pass per sample: shift, tap sweep, drain,
// then truncate the accumulator and saturate it to an N-bit result.
module fir_mac_sequencer #(
  parameter int N    = 25,
  parameter int TAPS = 8,
  parameter int AW   = $clog2(TAPS),
  parameter int LAT  = 2,
  parameter int FRAC = N - 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [2*N-2:0] i_producto,
  output logic [AW-1:0]  o_addr,
  output logic           o_shiftEn,
  output logic           o_accClr,
  output logic           o_busy,
  output logic           o_done,
  output logic [N-1:0]   o_resultado,
  output logic           o_overflow
);

  localparam int ACCW   = 2*N - 1 + AW;
  localparam int CNTMAX = (TAPS > LAT) ? TAPS : LAT;
  localparam int CW     = $clog2(CNTMAX) + 1;

  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, SHIFT, MAC, DRAIN, SAT} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CW-1:0]           r_cnt;
  logic [LAT-1:0]          r_vpipe;
  logic signed [ACCW-1:0]  r_acc;
  logic signed [ACCW-1:0]  w_prodExt;
  logic signed [ACCW-1:0]  w_q;
  logic                    w_vin;
  logic                    r_done;
  logic [N-1:0]            r_resultado;
  logic                    r_overflow;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    o_addr    = '0;
    o_shiftEn = 1'b0;
    o_accClr  = 1'b0;
    o_busy    = 1'b1;
    w_vin     = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = SHIFT;
      end
      SHIFT: begin
        o_shiftEn = 1'b1;
        o_accClr  = 1'b1;
        w_next    = MAC;
      end
      MAC: begin
        o_addr = r_cnt[AW-1:0];
        w_vin  = 1'b1;
        if (r_cnt == CW'(TAPS - 1)) w_next = DRAIN;
      end
      DRAIN: begin
        o_addr = AW'(TAPS - 1);
        if (r_cnt == CW'(LAT - 1)) w_next = SAT;
      end
      SAT: begin
        w_next = IDLE;
      end
      default: begin
        o_busy = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  // The phase counter restarts on every state change, so MAC and DRAIN share it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else                        r_cnt <= r_cnt + 1'b1;
  end

  assign w_prodExt = {{AW{i_producto[2*N-2]}}, i_producto};

  // The valid pipe tail marks the cycle in which Producto belongs to an issued tap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vpipe <= '0;
      r_acc   <= '0;
    end else begin
      r_vpipe <= (r_vpipe << 1) | LAT'(w_vin);
      if (r_state == SHIFT)      r_acc <= '0;
      else if (r_vpipe[LAT-1])   r_acc <= r_acc + w_prodExt;
    end
  end

  assign w_q = r_acc >>> FRAC;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_done      <= 1'b0;
      r_resultado <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= (r_state == SAT);
      if (r_state == SAT) begin
        if (w_q > SAT_MAX) begin
          r_resultado <= SAT_MAX[N-1:0];
          r_overflow  <= 1'b1;
        end else if (w_q < SAT_MIN) begin
          r_resultado <= SAT_MIN[N-1:0];
          r_overflow  <= 1'b1;
        end else begin
          r_resultado <= w_q[N-1:0];
          r_overflow  <= 1'b0;
        end
      end
    end
  end

  assign o_done      = r_done;
  assign o_resultado = r_resultado;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: table vectors, multi-cycle corner cases
// and random passes against a sum/floor/saturate reference model.
module tb_fir_mac_sequencer;

  localparam int N    = 8;
  localparam int TAPS = 4;
  localparam int LAT  = 2;
  localparam int FRAC = 7;
  localparam int AW   = 2;
  localparam int PW   = 2*N - 1;
  localparam int PASS = TAPS + LAT + 3;
  localparam int RMAX = (1 << (N-1)) - 1;
  localparam int RMIN = -(1 << (N-1));

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW-1:0] producto;
  logic [AW-1:0] addr;
  logic          shiftEn, accClr, busy, done, overflow;
  logic [N-1:0]  resultado;

  int            prodTab [TAPS];
  logic [AW-1:0] addrD1 = '0;
  logic [AW-1:0] addrD2 = '0;
  int            checks = 0;
  int            failures = 0;

  typedef struct {
    int p0, p1, p2, p3;
    int expRes;
    int expOvf;
  } vec_t;

  vec_t vecs [10];

  fir_mac_sequencer #(.N(N), .TAPS(TAPS), .AW(AW), .LAT(LAT), .FRAC(FRAC)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_producto(producto),
    .o_addr(addr), .o_shiftEn(shiftEn), .o_accClr(accClr), .o_busy(busy),
    .o_done(done), .o_resultado(resultado), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  // Datapath model: the product for the tap addressed in cycle c appears in cycle c+LAT.
  always @(posedge clk) begin
    addrD1 <= addr;
    addrD2 <= addrD1;
  end
  assign producto = PW'(prodTab[addrD2]);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic setTab(input int p0, input int p1, input int p2, input int p3);
    prodTab[0] = p0;
    prodTab[1] = p1;
    prodTab[2] = p2;
    prodTab[3] = p3;
  endtask

  function automatic void model(output int res, output int ovf);
    int sum, q;
    sum = 0;
    for (int i = 0; i < TAPS; i++) sum += prodTab[i];
    q = sum >>> FRAC;
    if (q > RMAX)      begin res = RMAX; ovf = 1; end
    else if (q < RMIN) begin res = RMIN; ovf = 1; end
    else               begin res = q;    ovf = 0; end
  endfunction

  function automatic int resInt();
    int r;
    r = $signed(resultado);
    return r;
  endfunction

  // One complete pass started from IDLE; returns Done latency and per-cycle observations.
  task automatic applyStimulus(output int lat, output int shiftCnt, output int busyCnt,
                               output int seqOk);
    int expAddr;
    lat = PASS * 3;
    shiftCnt = 0;
    busyCnt = 0;
    seqOk = 1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= PASS * 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (shiftEn) shiftCnt++;
      if (busy) busyCnt++;
      if (shiftEn != accClr) seqOk = 0;
      if ((k == 1) != shiftEn) seqOk = 0;
      if (k <= TAPS + LAT + 1) begin
        expAddr = (k <= 1) ? 0 : ((k <= TAPS + 1) ? k - 2 : TAPS - 1);
        if (int'(addr) != expAddr) seqOk = 0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input int expRes, input int expOvf);
    int lat, sc, bc, ok;
    applyStimulus(lat, sc, bc, ok);
    check({tag, ".doneLatency"}, lat, PASS);
    check({tag, ".shiftCount"}, sc, 1);
    check({tag, ".busyCycles"}, bc, TAPS + LAT + 2);
    check({tag, ".addrShiftSeq"}, ok, 1);
    check({tag, ".resultado"}, resInt(), expRes);
    check({tag, ".overflow"}, int'(overflow), expOvf);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int er, eo, k, shifts;
    vecs[0] = '{2560, 2560, 2560, 2560, 80, 0};
    vecs[1] = '{16000, 16000, 16000, 16000, 127, 1};
    vecs[2] = '{-16000, -16000, -16000, -16000, -128, 1};
    vecs[3] = '{-1, 0, 0, 0, -1, 0};
    vecs[4] = '{100, 200, -50, 0, 1, 0};
    vecs[5] = '{-200, 0, 0, 55, -2, 0};
    vecs[6] = '{16383, 0, 0, 0, 127, 0};
    vecs[7] = '{-16384, 0, 0, 0, -128, 0};
    vecs[8] = '{16383, 1, 0, 0, 127, 1};
    vecs[9] = '{-16384, -1, 0, 0, -128, 1};

    repeat (2) @(negedge clk);
    check("reset.addr", int'(addr), 0);
    check("reset.shiftEn", int'(shiftEn), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.resultado", resInt(), 0);
    check("reset.overflow", int'(overflow), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      setTab(vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
      checkOutput($sformatf("vec%0d", i), vecs[i].expRes, vecs[i].expOvf);
    end

    // Start held high: one SHIFT per pass, passes every PASS cycles.
    setTab(300, -20, 77, 5);
    model(er, eo);
    shifts = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 3 * PASS; c++) begin
      @(negedge clk);
      if (shiftEn) begin
        shifts++;
        check("held.shiftPhase", c % PASS, 1);
      end
      if (done) begin
        check("held.donePhase", c % PASS, 0);
        check("held.resultado", resInt(), er);
      end
      if (c == 3 * PASS) start = 1'b0;
    end
    check("held.shiftCount", shifts, 3);
    @(negedge clk);
    check("held.idleAfter", int'(busy), 0);

    // Back-to-back: restart in the Done cycle, old result held until the next Done.
    setTab(2560, 2560, 2560, 2560);
    @(negedge clk);
    start = 1'b1;
    k = 0;
    for (int c = 1; c <= 3 * PASS; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin k = c; break; end
    end
    check("b2b.firstLatency", k, PASS);
    check("b2b.firstResultado", resInt(), 80);
    setTab(-1, 0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b.shiftNext", int'(shiftEn), 1);
    k = 0;
    for (int c = 2; c <= 3 * PASS; c++) begin
      @(negedge clk);
      if (done) begin k = c; break; end
      if (resInt() != 80) check("b2b.heldResultado", resInt(), 80);
    end
    check("b2b.secondLatency", k, PASS);
    check("b2b.secondResultado", resInt(), -1);
    check("b2b.secondOverflow", int'(overflow), 0);

    // Reset during the third MAC cycle.
    setTab(16000, 16000, 16000, 16000);
    @(negedge clk);
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrst.busyBefore", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("midrst.addr", int'(addr), 0);
    check("midrst.shiftEn", int'(shiftEn), 0);
    check("midrst.accClr", int'(accClr), 0);
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.resultado", resInt(), 0);
    check("midrst.overflow", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    setTab(2560, 2560, 2560, 2560);
    checkOutput("afterRst", 80, 0);

    // Random passes against the reference model.
    for (int i = 0; i < 16; i++) begin
      for (int t = 0; t < TAPS; t++) prodTab[t] = int'($urandom_range(0, 32767)) - 16384;
      model(er, eo);
      checkOutput($sformatf("rand%0d", i), er, eo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
